// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NUM_REQ requesters.
// Optional abort-on-request-drop behaviour is enabled by defining INTERVAL_TIMER_ARB_ABORT_EN.
module interval_timer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_TICKS = 1023,
  parameter int WIDTH     = $clog2(MAX_TICKS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_ticks,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a requester raises req (level) and holds it; grant is the one-hot
  // owner while its window runs; done pulses for one cycle to end the window,
  // after which the requester may drop or re-raise req.
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t               state, state_d;
  logic [PTR_W-1:0]     ptr, ptr_d;
  logic [PTR_W-1:0]     winner, winner_d;
  logic [WIDTH-1:0]     target, target_d;
  logic [WIDTH-1:0]     count_d;
  logic [NUM_REQ-1:0]   grant_d, done_d;
  logic                 busy_d;

  logic [WIDTH-1:0]     ticks_arr [NUM_REQ];
  logic [PTR_W:0]       cand;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [WIDTH-1:0]     pick_ticks;
  logic [WIDTH-1:0]     count_inc;
  logic [PTR_W-1:0]     next_ptr;
  logic                 abort_now;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ticks_arr[i] = req_ticks[i*WIDTH +: WIDTH];
    end
  end

  // Scan from the pointer upwards, wrapping, and take the first active request.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!pick_found && req[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign pick_ticks = ticks_arr[pick_idx];
  assign count_inc  = count + WIDTH'(1);
  assign next_ptr   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);

`ifdef INTERVAL_TIMER_ARB_ABORT_EN
  assign abort_now = !req[winner];
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    winner_d = winner;
    target_d = target;
    count_d  = count;
    grant_d  = grant;
    done_d   = '0;
    busy_d   = busy;
    case (state)
      ST_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_found) begin
          state_d  = ST_RUN;
          winner_d = pick_idx;
          // A zero-length request still costs one tick.
          target_d = (pick_ticks == '0) ? WIDTH'(1) : pick_ticks;
          count_d  = '0;
          grant_d  = onehot(pick_idx);
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_now) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else if (tick_en) begin
          count_d = count_inc;
          if (count_inc == target) begin
            state_d = ST_DONE;
            grant_d = '0;
            done_d  = onehot(winner);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ptr_d   = next_ptr;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      winner <= '0;
      target <= '0;
      count  <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      winner <= winner_d;
      target <= target_d;
      count  <= count_d;
      grant  <= grant_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: grant order and done/count are
// scoreboarded against expected queues filled as each request is issued.
module tb_interval_timer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 10;
  localparam int DW      = NUM_REQ + WIDTH;

  logic                     clk;
  logic                     reset;
  logic                     tick_en;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_ticks;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [WIDTH-1:0]         count;

  logic [NUM_REQ-1:0] gnt_q[$];
  logic [DW-1:0]      exp_q[$];
  logic [NUM_REQ-1:0] prev_grant;

  int vectors     = 0;
  int miscompares = 0;
  int ndone       = 0;
  bit rel_on_done = 1'b1;

  interval_timer_arbiter #(.NUM_REQ(NUM_REQ), .MAX_TICKS(1023)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_en   (tick_en),
    .req       (req),
    .req_ticks (req_ticks),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ticks(input int i, input int v);
    req_ticks[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic push(input logic [NUM_REQ-1:0] g, input int final_count);
    gnt_q.push_back(g);
    exp_q.push_back({g, WIDTH'(final_count)});
  endtask

  // One cycle: sample at the falling edge and score any new grant or done pulse.
  task automatic cyc();
    logic [NUM_REQ-1:0] eg;
    logic [DW-1:0]      ed;
    @(negedge clk);
    if (grant != '0 && prev_grant == '0) begin
      eg = (gnt_q.size() != 0) ? gnt_q.pop_front() : '0;
      chk("grant_order", 32'(grant), 32'(eg));
    end
    if (done != '0) begin
      ed = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      chk("done_count", 32'({done, count}), 32'(ed));
      ndone++;
      if (rel_on_done) req = req & ~done;
    end
    prev_grant = grant;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int start;
    bit ok;
    start = ndone;
    ok    = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cyc();
      if (ndone - start >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    tick_en    = 1'b0;
    req        = '0;
    req_ticks  = '0;
    prev_grant = '0;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;

    // Single request, three ticks.
    set_ticks(1, 3);
    tick_en = 1'b1;
    req     = 4'b0010;
    push(4'b0010, 3);
    cyc();
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_busy",  32'(busy),  32'd1);
    cyc();
    chk("single_cnt1", 32'(count), 32'd1);
    cyc();
    chk("single_cnt2", 32'(count), 32'd2);
    cyc();
    chk("single_done",   32'(done),  32'h2);
    chk("single_gnt0",   32'(grant), 32'd0);
    chk("single_busy_d", 32'(busy),  32'd1);
    cyc();
    chk("single_done_1cyc", 32'(done), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a window.
    set_ticks(2, 10);
    req = 4'b0100;
    gnt_q.push_back(4'b0100);
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (grant != '0 && count == WIDTH'(5)) break;
    end
    chk("mid_run_count", 32'(count), 32'd5);
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_done",  32'(done),  32'd0);
    chk("async_busy",  32'(busy),  32'd0);
    chk("async_count", 32'(count), 32'd0);
    req = '0;
    cyc();
    reset = 1'b0;

    // All four requesting: strict rotation from index 0.
    rel_on_done = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_ticks(i, 2);
    req = 4'b1111;
    push(4'b0001, 2);
    push(4'b0010, 2);
    push(4'b0100, 2);
    push(4'b1000, 2);
    push(4'b0001, 2);
    wait_dones(5, 40);
    req = '0;
    rel_on_done = 1'b1;
    cyc();

    // Sparse ticks: count holds while tick_en is low.
    tick_en = 1'b0;
    set_ticks(1, 2);
    req = 4'b0010;
    push(4'b0010, 2);
    cyc();
    chk("stall_grant", 32'(grant), 32'h2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold0", 32'(count), 32'd0);
    end
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    chk("stall_cnt1", 32'(count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold1", 32'(count), 32'd1);
      chk("stall_nodone", 32'(done), 32'd0);
    end
    tick_en = 1'b1;
    cyc();
    tick_en = 1'b0;
    chk("stall_done", 32'(done),  32'h2);
    chk("stall_gnt0", 32'(grant), 32'd0);
    cyc();

    // Zero-length request behaves as one tick.
    tick_en = 1'b1;
    set_ticks(2, 0);
    req = 4'b0100;
    push(4'b0100, 1);
    cyc();
    chk("zero_grant", 32'(grant), 32'h4);
    chk("zero_cnt0",  32'(count), 32'd0);
    cyc();
    chk("zero_done", 32'(done),  32'h4);
    chk("zero_cnt1", 32'(count), 32'd1);
    cyc();

    // Short window on requester 3 to bring the pointer back to 0.
    set_ticks(3, 1);
    req = 4'b1000;
    push(4'b1000, 1);
    wait_dones(1, 10);
    cyc();

    // Winner drops its request mid-window.
    set_ticks(2, 5);
    set_ticks(3, 2);
    req = 4'b1100;
    gnt_q.push_back(4'b0100);
`ifndef INTERVAL_TIMER_ARB_ABORT_EN
    exp_q.push_back({4'b0100, WIDTH'(5)});
`endif
    push(4'b1000, 2);
    cyc();
    chk("abort_grant", 32'(grant), 32'h4);
    cyc();
    chk("abort_cnt1", 32'(count), 32'd1);
    req = 4'b1000;
    cyc();
`ifdef INTERVAL_TIMER_ARB_ABORT_EN
    chk("abort_gnt0",   32'(grant), 32'd0);
    chk("abort_busy0",  32'(busy),  32'd0);
    chk("abort_nodone", 32'(done),  32'd0);
    wait_dones(1, 20);
`else
    chk("noabort_gnt",  32'(grant), 32'h4);
    chk("noabort_cnt2", 32'(count), 32'd2);
    wait_dones(2, 30);
`endif
    repeat (3) cyc();

    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
